// File: rtl/mp3_track_ctrl.sv
// mp3_track_ctrl: button front end (synchronise + debounce + edge detect)
// and the IDLE/PLAYING/PAUSED/SWITCH track controller of an MP3 player.
// Optional build macro: MP3_TRACK_AUTO_NEXT_EN -- when defined, track_end
// while PLAYING behaves as a lowest-priority "next" event.
// Button events are single-cycle strobes with no back-pressure: an event
// that is not acted on in the cycle it occurs is lost.
module mp3_track_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int NUM_TRACKS      = 8,
  parameter int RST_HOLD        = 16
) (
  input  logic       clk_1M,
  input  logic       rst,
  input  logic       btn_play,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       track_end,
  output logic [2:0] music_id,
  output logic       start,
  output logic       player_rst,
  output logic       playing,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PLAYING = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] SWITCH  = 2'd3;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [2:0]    LAST_ID   = 3'(NUM_TRACKS - 1);

  // Button vectors: bit 0 play, bit 1 next, bit 2 prev.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    samp_q;    // previous synchronised sample, for run length
  logic [2:0]    deb_q;     // accepted (debounced) level
  logic [2:0]    valid_q;   // level accepted at least once since reset
  logic [CW-1:0] run_q [3]; // length of current run of identical samples
  logic [CW-1:0] run_d [3];
  logic [2:0]    accept;
  logic [2:0]    rise;

  assign btn_raw = {btn_prev, btn_next, btn_play};

  // Run-length of identical samples; accept a new level on the Nth sample.
  // The first acceptance after reset only establishes the level, so a
  // button held through reset never produces an event.
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < 3; i++) begin
      run_d[i] = run_q[i];
      if (sync2_q[i] != samp_q[i]) begin
        run_d[i] = CW'(1);
      end else if (run_q[i] != DEB_MAX) begin
        run_d[i] = run_q[i] + CW'(1);
      end
      accept[i] = (run_d[i] == DEB_MAX) && ((sync2_q[i] != deb_q[i]) || !valid_q[i]);
      rise[i]   = accept[i] && valid_q[i] && sync2_q[i];
    end
  end

  // Synchronisers, run counters and debounced levels.
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < 3; i++) begin
        run_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      samp_q  <= sync2_q;
      valid_q <= valid_q | accept;
      for (int i = 0; i < 3; i++) begin
        run_q[i] <= run_d[i];
        if (accept[i]) begin
          deb_q[i] <= sync2_q[i];
        end
      end
    end
  end

  logic [1:0]    state_q;
  logic [1:0]    origin_q;
  logic [HW-1:0] hold_q;
  logic          ev_play, ev_next, ev_prev, ev_auto;
  logic          go_next, go_prev;
  logic [2:0]    next_id, prev_id;

`ifdef MP3_TRACK_AUTO_NEXT_EN
  assign ev_auto = track_end && (state_q == PLAYING);
`else
  logic unused_track_end;
  assign unused_track_end = track_end;
  assign ev_auto = 1'b0;
`endif

  assign ev_play = rise[0];
  assign ev_next = rise[1];
  assign ev_prev = rise[2];
  // next > prev > play > auto-next; losers in the same cycle are dropped.
  assign go_next = ev_next || (ev_auto && !ev_prev && !ev_play);
  assign go_prev = ev_prev && !ev_next;
  assign next_id = (music_id == LAST_ID) ? 3'd0 : music_id + 3'd1;
  assign prev_id = (music_id == 3'd0) ? LAST_ID : music_id - 3'd1;

  // Track FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      state_q    <= IDLE;
      origin_q   <= IDLE;
      hold_q     <= '0;
      music_id   <= '0;
      start      <= 1'b0;
      player_rst <= 1'b0;
    end else if (state_q == SWITCH) begin
      if (hold_q == HOLD_LAST) begin
        state_q    <= origin_q;
        player_rst <= 1'b0;
        start      <= (origin_q == PLAYING);
        hold_q     <= '0;
      end else begin
        hold_q <= hold_q + HW'(1);
      end
    end else if (go_next || go_prev) begin
      origin_q   <= state_q;
      state_q    <= SWITCH;
      hold_q     <= '0;
      player_rst <= 1'b1;
      start      <= 1'b0;
      music_id   <= go_next ? next_id : prev_id;
    end else if (ev_play) begin
      if (state_q == PLAYING) begin
        state_q <= PAUSED;
        start   <= 1'b0;
      end else begin
        state_q <= PLAYING;
        start   <= 1'b1;
      end
    end
  end

  assign playing   = start;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mp3_track_ctrl.sv
// tb_mp3_track_ctrl: vector table + directed corner sequences + random
// stimulus, all checked against a sample-window reference model.
module tb_mp3_track_ctrl;

  localparam int DEB = 4;
  localparam int RH  = 3;
  localparam int NT  = 8;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAYING = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;

  logic       clk_1M, rst;
  logic       btn_play, btn_next, btn_prev, track_end;
  logic [2:0] music_id;
  logic       start, player_rst, playing;
  logic [1:0] state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  mp3_track_ctrl #(.DEBOUNCE_CYCLES(DEB), .NUM_TRACKS(NT), .RST_HOLD(RH)) dut (
    .clk_1M(clk_1M), .rst(rst), .btn_play(btn_play), .btn_next(btn_next),
    .btn_prev(btn_prev), .track_end(track_end), .music_id(music_id),
    .start(start), .player_rst(player_rst), .playing(playing),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk_1M = 1'b0;
  always #5 clk_1M = ~clk_1M;

  // ---------------- reference model ----------------
  // Raw presses appear two samples late; a level is accepted when the last
  // DEB samples all agree and differ from the held level (or none held yet).
  logic [2:0] raw_q[$];
  logic [2:0] win_q[$];
  logic [2:0] m_lvl = '0;
  logic [2:0] m_vld = '0;
  int m_mode   = 0;   // 0 idle, 1 playing, 2 paused, 3 switching
  int m_origin = 0;
  int m_left   = 0;
  int m_id     = 0;

  task automatic model_step();
    logic [2:0] smp;
    logic [2:0] ev;
    bit uni, auto_ev;
    if (rst) begin
      raw_q.delete(); win_q.delete();
      m_lvl = '0; m_vld = '0; m_mode = 0; m_origin = 0; m_left = 0; m_id = 0;
      return;
    end
    raw_q.push_back({btn_prev, btn_next, btn_play});
    smp = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : 3'b000;
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    win_q.push_back(smp);
    if (win_q.size() > DEB) void'(win_q.pop_front());
    ev = '0;
    for (int b = 0; b < 3; b++) begin
      uni = (win_q.size() == DEB);
      foreach (win_q[j]) if (win_q[j][b] != smp[b]) uni = 0;
      if (uni && (smp[b] != m_lvl[b] || !m_vld[b])) begin
        if (m_vld[b] && smp[b]) ev[b] = 1'b1;
        m_lvl[b] = smp[b];
        m_vld[b] = 1'b1;
      end
    end
    if (m_mode == 3) begin
      if (m_left == 1) m_mode = m_origin;
      else m_left = m_left - 1;
      return;
    end
    auto_ev = 0;
`ifdef MP3_TRACK_AUTO_NEXT_EN
    auto_ev = track_end && (m_mode == 1);
`endif
    if (ev[1] || (auto_ev && !ev[2] && !ev[0])) begin
      m_origin = m_mode; m_mode = 3; m_left = RH; m_id = (m_id + 1) % NT;
    end else if (ev[2]) begin
      m_origin = m_mode; m_mode = 3; m_left = RH; m_id = (m_id + NT - 1) % NT;
    end else if (ev[0]) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

  always @(posedge clk_1M) model_step();

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_model();
    check("mdl_music_id",   32'(music_id),   32'(m_id));
    check("mdl_start",      32'(start),      32'(m_mode == 1));
    check("mdl_player_rst", 32'(player_rst), 32'(m_mode == 3));
    check("mdl_playing",    32'(playing),    32'(m_mode == 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_1M);
    cmp_model();
  endtask

  task automatic set_btns(input logic [2:0] b);
    {btn_prev, btn_next, btn_play} = b;
  endtask

  task automatic press(input logic [2:0] b, input int hold, input int settle);
    set_btns(b);
    repeat (hold) tick();
    set_btns(3'b000);
    repeat (settle) tick();
  endtask

  task automatic wait_player_rst(input int limit);
    bit ok;
    ok = 0;
    for (int c = 0; c < limit && !ok; c++) begin
      tick();
      if (player_rst === 1'b1) ok = 1;
    end
    check("wait_player_rst", 32'(ok), 32'd1);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] id, input logic st, input logic [1:0] s);
    check({tag, "_music_id"},   32'(music_id),   32'(id));
    check({tag, "_start"},      32'(start),      32'(st));
    check({tag, "_playing"},    32'(playing),    32'(st));
    check({tag, "_player_rst"}, 32'(player_rst), 32'd0);
    check({tag, "_state"},      32'(state_dbg),  32'(s));
  endtask

  typedef struct {
    logic [2:0] btns;   // {prev, next, play}
    int         hold;
    logic [2:0] exp_id;
    logic       exp_start;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs [13];
  int   rises, cnt, hold, r;
  logic prev_s;
  logic [2:0] rb;
  logic [2:0] exp_d;

  initial begin
    // vector table: starts from PLAYING, music_id 0
    vecs[0]  = '{3'b001, 10, 3'd0, 1'b0, S_PAUSED};
    vecs[1]  = '{3'b001, 10, 3'd0, 1'b1, S_PLAYING};
    vecs[2]  = '{3'b010, 10, 3'd1, 1'b1, S_PLAYING};
    vecs[3]  = '{3'b100, 10, 3'd0, 1'b1, S_PLAYING};
    vecs[4]  = '{3'b100, 10, 3'd7, 1'b1, S_PLAYING};
    vecs[5]  = '{3'b010, 10, 3'd0, 1'b1, S_PLAYING};
    vecs[6]  = '{3'b001, 10, 3'd0, 1'b0, S_PAUSED};
    vecs[7]  = '{3'b001,  2, 3'd0, 1'b0, S_PAUSED};   // glitch
    vecs[8]  = '{3'b010, 10, 3'd1, 1'b0, S_PAUSED};
    vecs[9]  = '{3'b011, 10, 3'd2, 1'b0, S_PAUSED};   // next beats play
    vecs[10] = '{3'b110, 10, 3'd3, 1'b0, S_PAUSED};   // next beats prev
    vecs[11] = '{3'b101, 10, 3'd2, 1'b0, S_PAUSED};   // prev beats play
    vecs[12] = '{3'b001, 10, 3'd2, 1'b1, S_PLAYING};

    rst = 1'b1; track_end = 1'b0; set_btns(3'b000);
    repeat (3) @(negedge clk_1M);
    chk_state("reset", 3'd0, 1'b0, S_IDLE);
    rst = 1'b0;
    repeat (10) tick();

    // single long play press from IDLE -> exactly one event
    rises = 0; prev_s = start;
    btn_play = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c == 10) btn_play = 1'b0;
      tick();
      if (start && !prev_s) rises++;
      prev_s = start;
    end
    check("play_event_count", 32'(rises), 32'd1);
    chk_state("first_play", 3'd0, 1'b1, S_PLAYING);

    for (int i = 0; i < 13; i++) begin
      press(vecs[i].btns, vecs[i].hold, 12);
      chk_state($sformatf("tbl%0d", i), vecs[i].exp_id, vecs[i].exp_start, vecs[i].exp_state);
    end

    // wrap 7 -> 0 with exact player_rst width, then 0 -> 7
    repeat (3) press(3'b100, 10, 12);
    chk_state("at7", 3'd7, 1'b1, S_PLAYING);
    btn_next = 1'b1;
    wait_player_rst(20);
    cnt = 0;
    while (player_rst === 1'b1 && cnt < 10) begin
      check("start_low_in_switch", 32'(start), 32'd0);
      cnt++;
      tick();
    end
    check("player_rst_cycles", 32'(cnt), 32'(RH));
    check("wrap_next_id", 32'(music_id), 32'd0);
    check("wrap_next_start", 32'(start), 32'd1);
    btn_next = 1'b0;
    repeat (12) tick();
    press(3'b100, 10, 12);
    chk_state("wrap_prev", 3'd7, 1'b1, S_PLAYING);

    // reset in the 2nd SWITCH cycle, with next held across reset release
    btn_next = 1'b1;
    wait_player_rst(20);
    tick();
    check("second_switch_cycle", 32'(player_rst), 32'd1);
    rst = 1'b1;
    tick();
    chk_state("rst_mid_switch", 3'd0, 1'b0, S_IDLE);
    rst = 1'b0;
    repeat (12) tick();
    chk_state("held_over_rst", 3'd0, 1'b0, S_IDLE);
    btn_next = 1'b0;
    repeat (12) tick();
    press(3'b010, 10, 12);
    chk_state("after_rst_next", 3'd1, 1'b0, S_IDLE);

    // track_end while PLAYING and while PAUSED
    press(3'b001, 10, 12);
`ifdef MP3_TRACK_AUTO_NEXT_EN
    exp_d = 3'd2;
`else
    exp_d = 3'd1;
`endif
    track_end = 1'b1; tick(); track_end = 1'b0;
    repeat (10) tick();
    chk_state("track_end_playing", exp_d, 1'b1, S_PLAYING);
    press(3'b001, 10, 12);
    track_end = 1'b1; tick(); track_end = 1'b0;
    repeat (10) tick();
    chk_state("track_end_paused", exp_d, 1'b0, S_PAUSED);

    // random stimulus against the model
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end else begin
        rb = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 9);
        set_btns(rb);
        for (int c = 0; c < hold; c++) begin
          track_end = ($urandom_range(0, 9) == 0);
          tick();
        end
        track_end = 1'b0;
        set_btns(3'b000);
        repeat ($urandom_range(0, 8)) tick();
      end
    end
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mp3_track_ctrl.md
MP3_TRACK_CTRL -- requirements
Module: mp3_track_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, consecutive stable clk_1M cycles required to accept a button level (20 ms).
REQ-002 SHALL have parameter NUM_TRACKS, default 8, number of selectable tracks (1..8).
REQ-003 SHALL have parameter RST_HOLD, default 16, clk_1M cycles player_rst is held high on a track switch.
REQ-004 SHALL have port clk_1M  input  1  1 MHz system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port btn_play  input  1  raw asynchronous play/pause button, active-high.
REQ-007 SHALL have port btn_next  input  1  raw asynchronous next-track button, active-high.
REQ-008 SHALL have port btn_prev  input  1  raw asynchronous previous-track button, active-high.
REQ-009 SHALL have port track_end  input  1  one-cycle pulse from the player at end of current track data.
REQ-010 SHALL have port music_id  output  3  selected track, drives the player's track select.
REQ-011 SHALL have port start  output  1  player run enable; high only in PLAYING.
REQ-012 SHALL have port player_rst  output  1  player restart, high only in SWITCH.
REQ-013 SHALL have port playing  output  1  status, equal to start.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer before debounce.
REQ-015 SHALL debounce each button independently: a level change is accepted after exactly DEBOUNCE_CYCLES consecutive identical synchronized samples; any differing sample restarts the count.
REQ-016 SHALL generate a one-cycle event on each accepted 0->1 debounced transition; no events on release or while held.
REQ-017 SHALL implement states IDLE, PLAYING, PAUSED, SWITCH.
REQ-018 SHALL transition IDLE -play-> PLAYING, PLAYING -play-> PAUSED, PAUSED -play-> PLAYING.
REQ-019 SHALL, on next or prev in IDLE/PLAYING/PAUSED, enter SWITCH, record the origin state and update music_id in the same cycle.
REQ-020 SHALL apply event priority next > prev > play when several occur in one cycle; lower-priority events in that cycle are discarded.
REQ-021 SHALL wrap music_id: NUM_TRACKS-1 + next -> 0; 0 + prev -> NUM_TRACKS-1.
REQ-022 SHALL hold player_rst=1 and start=0 for exactly RST_HOLD cycles in SWITCH, then return to the recorded origin state.
REQ-023 SHALL ignore all button events and track_end while in SWITCH.
REQ-024 SHALL change start and player_rst only on state change, registered (one cycle after the event).

Reset
REQ-025 SHALL on rst set state IDLE, music_id=0, start=0, player_rst=0, playing=0, debounce counters 0, debounced levels 0, synchronizers 0.
REQ-026 SHALL, on rst asserted mid-SWITCH, abort the switch immediately and deassert player_rst next cycle.
REQ-027 SHALL require a button held across rst release to be re-accepted via full debounce, generating an event only on a later 0->1 change.

Configuration
REQ-028 SHALL, with macro MP3_TRACK_AUTO_NEXT_EN defined, treat track_end in PLAYING as a next event (lowest priority, below play).
REQ-029 SHALL, without MP3_TRACK_AUTO_NEXT_EN, ignore track_end in all states.

Verification (bench: DEBOUNCE_CYCLES=4, RST_HOLD=3, NUM_TRACKS=8)
REQ-030 SHALL verify: btn_play high 10 cycles from IDLE -> exactly one event, start=1, playing=1; second press -> start=0 (PAUSED).
REQ-031 SHALL verify: btn_play glitch high 2 cycles -> no event, state unchanged.
REQ-032 SHALL verify: PLAYING, music_id=7, press next -> music_id=0, player_rst=1 for exactly 3 cycles, start=0 meanwhile, then start=1; from music_id=0 prev -> 7.
REQ-033 SHALL verify: next and play debounced in same cycle from PAUSED -> music_id+1, returns to PAUSED, play discarded.
REQ-034 SHALL verify: rst pulsed in 2nd SWITCH cycle -> player_rst=0, music_id=0, IDLE next cycle.
REQ-035 SHALL verify: PLAYING, track_end pulse -> with MP3_TRACK_AUTO_NEXT_EN music_id+1 via SWITCH; without, no change.
